weight_fetch: RTL
=================

# weight_fetch

Drains the ping-pong weight SRAM pair that the weight write port has just filled, and streams 256-bit weight words to the compute array. It sits directly downstream of the write port. It shares the same four 128-bit banks: pair 0 = banks 0/1, pair 1 = banks 2/3. It also shares the same persistent byte-address progression: step 16, wrap at the limit, flip pair. The write side reports "pair full" and the fetch side returns "pair free", so the two ends never touch the same pair at once.

## Interface
Parameters:
- ADDR_W, 15, SRAM byte-address width
- ADDR_STEP, 16, byte increment per 128-bit word
- PP_ADDR_LIMIT, 32752, last address of a pair; reading it flips the pair
- CNT_W, 13, burst-length width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_start  in  1  start pulse; accepted only in IDLE
- tran_time  in  CNT_W  beats in this burst, sampled at fetch_start; 0 is treated as 1
- pp_full_set  in  2  one-cycle pulse per pair: the write side finished filling that pair
- pp_free  out  2  one-cycle pulse per pair: fetch read that pair's last address and released it
- rce_0..rce_3  out  1 each  SRAM read enables
- raddr_0..raddr_3  out  ADDR_W each  read addresses; all four carry the same value
- rdata_0..rdata_3  in  128 each  SRAM read data, valid 1 cycle after rce
- w_valid  out  1  stream valid
- w_ready  in  1  stream ready
- w_data  out  256  pair 0: {rdata_1, rdata_0}; pair 1: {rdata_3, rdata_2}
- w_last  out  1  marks the final beat of the burst
- done  out  1  one-cycle pulse after the final beat is accepted
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
Internal state:
- full[1:0] flags
- pp pointer (initially 0)
- persistent global_addr (initially 0)
- beat counters: issued and delivered
- 2-entry output FIFO

Flag handling:
- pp_full_set[i] sets full[i].
- Reading address PP_ADDR_LIMIT of pair pp clears full[pp], pulses pp_free[pp] on the next cycle, flips pp and resets global_addr to 0.
- If a set and a clear hit the same flag in the same cycle, the set wins.

FSM states and transitions:
- IDLE: on fetch_start, latch tran_time and clear both counters. Go to READ if full[pp], else to WAIT_BANK.
- WAIT_BANK: no reads are issued. Go to READ once full[pp]=1.
- READ: issue one read per cycle when credit allows. Credit means FIFO occupancy + in-flight reads < 2.
  - The rce pair for pp asserts, the other pair stays low, and raddr = global_addr.
  - global_addr then advances by ADDR_STEP, or wraps as described above.
  - If a wrap lands on a pair that is not full, go to WAIT_BANK. The burst continues from there.
  - When issued = length, go to DRAIN.
- DRAIN: wait until delivered = length, then pulse done and go to IDLE.

Datapath:
- Each in-flight read carries its pair tag. The FIFO captures the correctly mapped 256-bit word.
- w_last is set on the entry whose delivered index equals length−1.
- fetch_start outside IDLE is ignored.

## Timing
- Reset: every output is 0; full=00, pp=0, global_addr=0, FIFO empty, FSM in IDLE.
- Reset in the middle of a burst abandons the burst and drops all in-flight data.
- Latency with the pair full: fetch_start at cycle T, first rce at T+1, first w_valid at T+2.
- Throughput is 1 beat/cycle while w_ready=1.
- When w_ready is low, the FIFO fills, issue stops within one cycle, and no data is lost.
- w_data and w_last hold stable while w_valid && !w_ready.
- done pulses in the cycle after the handshake of the last beat. busy falls in the same cycle that done pulses.
- pp_free pulses one cycle after the rce that read address PP_ADDR_LIMIT.

## Structure
- Shared package weight_pp_pkg holds:
  - ADDR_W, ADDR_STEP, PP_ADDR_LIMIT, CNT_W
  - the pair-select encoding
  - the FSM state enum (IDLE, WAIT_BANK, READ, DRAIN)
- The write port already uses the same constants and must import this package too.
- One sub-module: weight_fetch_fifo, a 2-entry 257-bit (data + last) FIFO with full/empty/count outputs.

## Test plan
- Basic burst: pp_full_set=01, then fetch_start with tran_time=4 and w_ready=1.
  - Expected: rce_0/rce_1 high for 4 cycles with raddr 0, 16, 32, 48.
  - Expected: 4 beats in order, w_last on beat 4, done at T+6.
- Wait for bank: fetch_start with full=00.
  - Expected: FSM holds in WAIT_BANK with no rce. After pp_full_set=01, first rce 1 cycle later.
- Wrap mid-burst: global_addr preloaded to 32736, full=11, tran_time=4.
  - Expected: reads at 32736 and 32752 on banks 0/1, then 0 and 16 on banks 2/3.
  - Expected: pp_free=01 pulse; w_data switches to the {rdata_3, rdata_2} mapping.
- Backpressure: toggle w_ready randomly across a 16-beat burst.
  - Expected: all 16 words delivered once, in address order, with w_data stable while stalled.
- Flag collision and reset: pp_full_set[0] in the same cycle as the pair-0 clear.
  - Expected: full[0] stays 1.
- Reset asserted mid-burst.
  - Expected: all outputs 0 next cycle, FSM in IDLE, global_addr=0.

Source files
------------

// File: rtl/weight_pp_pkg.sv
// Constants and encodings shared by the ping-pong weight SRAM write port and fetch engine.
package weight_pp_pkg;

    localparam int ADDR_W        = 15;
    localparam int ADDR_STEP     = 16;
    localparam int PP_ADDR_LIMIT = 32752;
    localparam int CNT_W         = 13;
    localparam int BANK_W        = 128;

    // Pair 0 owns banks 0/1, pair 1 owns banks 2/3.
    typedef enum logic {
        PAIR_0 = 1'b0,
        PAIR_1 = 1'b1
    } pair_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        READ      = 2'd2,
        DRAIN     = 2'd3
    } fetch_state_e;

    function automatic pair_e other_pair(input pair_e p);
        return (p == PAIR_0) ? PAIR_1 : PAIR_0;
    endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// Two-entry FIFO holding fetched weight words plus their last-beat flag.
module weight_fetch_fifo #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; an entry is only read after count says it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch.sv
// Drains a filled ping-pong SRAM pair and streams 256-bit weight words to the compute array.
module weight_fetch
    import weight_pp_pkg::*;
#(
    parameter int ADDR_W        = weight_pp_pkg::ADDR_W,
    parameter int ADDR_STEP     = weight_pp_pkg::ADDR_STEP,
    parameter int PP_ADDR_LIMIT = weight_pp_pkg::PP_ADDR_LIMIT,
    parameter int CNT_W         = weight_pp_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic [CNT_W-1:0]  tran_time,
    input  logic [1:0]        pp_full_set,
    output logic [1:0]        pp_free,
    output logic              rce_0,
    output logic              rce_1,
    output logic              rce_2,
    output logic              rce_3,
    output logic [ADDR_W-1:0] raddr_0,
    output logic [ADDR_W-1:0] raddr_1,
    output logic [ADDR_W-1:0] raddr_2,
    output logic [ADDR_W-1:0] raddr_3,
    input  logic [127:0]      rdata_0,
    input  logic [127:0]      rdata_1,
    input  logic [127:0]      rdata_2,
    input  logic [127:0]      rdata_3,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [255:0]      w_data,
    output logic              w_last,
    output logic              done,
    output logic              busy
);

    localparam int WORD_W = 2 * BANK_W;

    fetch_state_e      state;
    pair_e             pp;
    pair_e             pp_nxt;
    pair_e             in_pair;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [1:0]        clr;
    logic [ADDR_W-1:0] global_addr;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  delivered;
    logic              in_valid;
    logic              in_last;
    logic              credit;
    logic              issue;
    logic              at_limit;
    logic              wrap;
    logic              hs;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [WORD_W-1:0] mapped;
    logic [WORD_W:0]   fifo_rdata;
    logic [WORD_W:0]   head;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        credit   = (fifo_count == 2'd0) || (!fifo_full && !in_valid);
        issue    = (state == READ) && credit && (issued != len);
        at_limit = (global_addr == ADDR_W'(PP_ADDR_LIMIT));
        wrap     = issue && at_limit;
        clr      = 2'b00;
        pp_nxt   = pp;
        if (wrap) begin
            clr    = (pp == PAIR_1) ? 2'b10 : 2'b01;
            pp_nxt = other_pair(pp);
        end
        // A set landing on the flag being cleared wins.
        full_nxt = (full & ~clr) | pp_full_set;
    end

    assign rce_0   = issue && (pp == PAIR_0);
    assign rce_1   = issue && (pp == PAIR_0);
    assign rce_2   = issue && (pp == PAIR_1);
    assign rce_3   = issue && (pp == PAIR_1);
    assign raddr_0 = issue ? global_addr : '0;
    assign raddr_1 = raddr_0;
    assign raddr_2 = raddr_0;
    assign raddr_3 = raddr_0;
    assign busy    = (state != IDLE);

    // An empty FIFO is bypassed so the SRAM word reaches the stream the cycle it returns.
    assign mapped    = (in_pair == PAIR_1) ? {rdata_3, rdata_2} : {rdata_1, rdata_0};
    assign head      = fifo_empty ? {in_last, mapped} : fifo_rdata;
    assign w_valid   = !fifo_empty || in_valid;
    assign w_data    = w_valid ? head[WORD_W-1:0] : '0;
    assign w_last    = w_valid && head[WORD_W];
    assign hs        = w_valid && w_ready;
    assign fifo_push = in_valid && !(fifo_empty && w_ready);
    assign fifo_pop  = !fifo_empty && w_ready;

    weight_fetch_fifo #(.W(WORD_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_last, mapped}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pp          <= PAIR_0;
            full        <= 2'b00;
            global_addr <= '0;
            len         <= '0;
            issued      <= '0;
            delivered   <= '0;
            in_valid    <= 1'b0;
            in_pair     <= PAIR_0;
            in_last     <= 1'b0;
            pp_free     <= 2'b00;
            done        <= 1'b0;
        end else begin
            full     <= full_nxt;
            pp       <= pp_nxt;
            pp_free  <= clr;
            done     <= 1'b0;
            in_valid <= issue;
            in_pair  <= pp;
            in_last  <= (issued == len - CNT_W'(1));
            if (issue) begin
                global_addr <= at_limit ? '0 : global_addr + ADDR_W'(ADDR_STEP);
                issued      <= issued + CNT_W'(1);
            end
            if (hs) delivered <= delivered + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        len       <= (tran_time == '0) ? CNT_W'(1) : tran_time;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= full_nxt[pp_nxt] ? READ : WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    if (full_nxt[pp_nxt]) state <= READ;
                end
                READ: begin
                    if (issue) begin
                        if (issued + CNT_W'(1) == len)     state <= DRAIN;
                        else if (wrap && !full_nxt[pp_nxt]) state <= WAIT_BANK;
                    end
                end
                DRAIN: begin
                    if (hs && (delivered == len - CNT_W'(1))) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
